// File: rtl/ibex_pkg.sv
// Shared types for the register-file writeback arbiter: destination select and
// buffered FPU result entry.
package ibex_pkg;

  typedef enum logic {
    RF_SEL_INT = 1'b0,
    RF_SEL_FP  = 1'b1
  } rf_sel_e;

  typedef struct packed {
    rf_sel_e     sel;
    logic [4:0]  waddr;
    logic [31:0] wdata;
  } rf_wb_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [4:0] addr);
    return 32'b1 << addr;
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// In-order FIFO of buffered FPU results. Exposes per-entry valid, select and
// address so the parent can build register pending masks.
module ibex_rf_wb_fifo
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         push_i,
  input  rf_wb_entry_t                 push_data_i,
  input  logic                         pop_i,
  output rf_wb_entry_t                 head_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(Depth+1)-1:0]   count_o,
  output logic [Depth-1:0]             valid_o,
  output logic [Depth-1:0]             entry_sel_o,
  output logic [4:0]                   entry_waddr_o [Depth]
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  rf_wb_entry_t    mem_q [Depth];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(Depth - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // NOTE: every signal driven from always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
    if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: storage is not reset; an entry is only observed while count marks it valid.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  // An entry is live when its distance from the read pointer is below count.
  always_comb begin
    valid_o = '0;
    for (int i = 0; i < Depth; i++) begin
      valid_o[i] = ((unsigned'(i) + Depth - 32'(rd_ptr_q)) % Depth) < 32'(count_q);
    end
  end

  always_comb begin
    entry_sel_o = '0;
    for (int i = 0; i < Depth; i++) begin
      entry_sel_o[i]   = (mem_q[i].sel == RF_SEL_FP);
      entry_waddr_o[i] = mem_q[i].waddr;
    end
  end

  assert property (@(posedge clk_i) disable iff (!rst_ni) push_i |-> !full_o);
  assert property (@(posedge clk_i) disable iff (!rst_ni) pop_i |-> !empty_o);

endmodule

// File: rtl/ibex_rf_wb_arbiter.sv
// Merges writeback-stage RF writes with buffered multi-cycle FPU results.
// Optional same-cycle FPU bypass when IBEX_RF_WB_BYPASS_EN is defined.
module ibex_rf_wb_arbiter
  import ibex_pkg::*;
#(
  parameter int unsigned Depth = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        rf_we_wb_i,
  input  logic        rf_fp_wb_i,
  input  logic [4:0]  rf_waddr_wb_i,
  input  logic [31:0] rf_wdata_wb_i,
  input  logic        fpu_valid_i,
  output logic        fpu_ready_o,
  input  logic        fpu_fp_i,
  input  logic [4:0]  fpu_waddr_i,
  input  logic [31:0] fpu_wdata_i,
  output logic        rf_we_int_o,
  output logic [4:0]  rf_waddr_int_o,
  output logic [31:0] rf_wdata_int_o,
  output logic        rf_we_fp_o,
  output logic [4:0]  rf_waddr_fp_o,
  output logic [31:0] rf_wdata_fp_o,
  output logic [31:0] pend_int_o,
  output logic [31:0] pend_fp_o,
  output logic        idle_o
);

  rf_wb_entry_t                fifo_head;
  rf_wb_entry_t                fifo_in;
  logic                        fifo_full, fifo_empty, fifo_push;
  logic [$clog2(Depth+1)-1:0]  fifo_count;
  logic [Depth-1:0]            fifo_valid, fifo_sel;
  logic [4:0]                  fifo_waddr [Depth];

  logic wb_int, wb_fp;
  logic accept, discard, bypass;
  logic head_busy, drain, drain_int, drain_fp, bypass_int, bypass_fp;

  assign wb_int = rf_we_wb_i & ~rf_fp_wb_i;
  assign wb_fp  = rf_we_wb_i &  rf_fp_wb_i;

  assign fpu_ready_o = ~fifo_full;
  assign accept      = fpu_valid_i & fpu_ready_o;
  assign discard     = accept & ~fpu_fp_i & (fpu_waddr_i == 5'd0);

`ifdef IBEX_RF_WB_BYPASS_EN
  logic fpu_port_busy;
  assign fpu_port_busy = fpu_fp_i ? wb_fp : wb_int;
  // With an empty FIFO there is no older result to overtake, so a free port can be written directly.
  assign bypass = accept & ~discard & fifo_empty & ~fpu_port_busy;
`else
  assign bypass = 1'b0;
`endif

  assign fifo_push = accept & ~discard & ~bypass;
  assign fifo_in   = '{sel: rf_sel_e'(fpu_fp_i), waddr: fpu_waddr_i, wdata: fpu_wdata_i};

  // Only the head may drain; a blocked head holds back every younger entry.
  assign head_busy  = (fifo_head.sel == RF_SEL_FP) ? wb_fp : wb_int;
  assign drain      = ~fifo_empty & ~head_busy;
  assign drain_int  = drain & (fifo_head.sel == RF_SEL_INT);
  assign drain_fp   = drain & (fifo_head.sel == RF_SEL_FP);
  assign bypass_int = bypass & ~fpu_fp_i;
  assign bypass_fp  = bypass &  fpu_fp_i;

  ibex_rf_wb_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .push_i        (fifo_push),
    .push_data_i   (fifo_in),
    .pop_i         (drain),
    .head_o        (fifo_head),
    .full_o        (fifo_full),
    .empty_o       (fifo_empty),
    .count_o       (fifo_count),
    .valid_o       (fifo_valid),
    .entry_sel_o   (fifo_sel),
    .entry_waddr_o (fifo_waddr)
  );

  always_comb begin
    rf_we_int_o    = 1'b0;
    rf_waddr_int_o = '0;
    rf_wdata_int_o = '0;
    if (wb_int) begin
      rf_we_int_o    = 1'b1;
      rf_waddr_int_o = rf_waddr_wb_i;
      rf_wdata_int_o = rf_wdata_wb_i;
    end else if (drain_int) begin
      rf_we_int_o    = 1'b1;
      rf_waddr_int_o = fifo_head.waddr;
      rf_wdata_int_o = fifo_head.wdata;
    end else if (bypass_int) begin
      rf_we_int_o    = 1'b1;
      rf_waddr_int_o = fpu_waddr_i;
      rf_wdata_int_o = fpu_wdata_i;
    end
  end

  always_comb begin
    rf_we_fp_o    = 1'b0;
    rf_waddr_fp_o = '0;
    rf_wdata_fp_o = '0;
    if (wb_fp) begin
      rf_we_fp_o    = 1'b1;
      rf_waddr_fp_o = rf_waddr_wb_i;
      rf_wdata_fp_o = rf_wdata_wb_i;
    end else if (drain_fp) begin
      rf_we_fp_o    = 1'b1;
      rf_waddr_fp_o = fifo_head.waddr;
      rf_wdata_fp_o = fifo_head.wdata;
    end else if (bypass_fp) begin
      rf_we_fp_o    = 1'b1;
      rf_waddr_fp_o = fpu_waddr_i;
      rf_wdata_fp_o = fpu_wdata_i;
    end
  end

  // Masks come from registered entries only, so a draining entry is still shown.
  always_comb begin
    pend_int_o = '0;
    pend_fp_o  = '0;
    for (int i = 0; i < Depth; i++) begin
      if (fifo_valid[i]) begin
        if (fifo_sel[i]) pend_fp_o  = pend_fp_o  | reg_onehot(fifo_waddr[i]);
        else             pend_int_o = pend_int_o | reg_onehot(fifo_waddr[i]);
      end
    end
    pend_int_o[0] = 1'b0;
  end

  assign idle_o = (fifo_count == '0);

  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0({wb_int, drain_int, bypass_int}));
  assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0({wb_fp, drain_fp, bypass_fp}));

endmodule

// File: tb/tb_ibex_rf_wb_arbiter.sv
// Directed self-checking bench for ibex_rf_wb_arbiter (Depth = 2).
module tb_ibex_rf_wb_arbiter;

`ifdef IBEX_RF_WB_BYPASS_EN
  localparam bit Bypass = 1'b1;
`else
  localparam bit Bypass = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rf_we_wb = 1'b0, rf_fp_wb = 1'b0;
  logic [4:0]  rf_waddr_wb = '0;
  logic [31:0] rf_wdata_wb = '0;
  logic        fpu_valid = 1'b0, fpu_fp = 1'b0;
  logic [4:0]  fpu_waddr = '0;
  logic [31:0] fpu_wdata = '0;
  logic        fpu_ready, we_int, we_fp, idle;
  logic [4:0]  waddr_int, waddr_fp;
  logic [31:0] wdata_int, wdata_fp, pend_int, pend_fp;

  int checks = 0;
  int passed = 0;

  wire [37:0] int_port = {we_int, waddr_int, wdata_int};
  wire [37:0] fp_port  = {we_fp, waddr_fp, wdata_fp};

  always #5 clk = ~clk;

  ibex_rf_wb_arbiter #(.Depth(2)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .rf_we_wb_i     (rf_we_wb),
    .rf_fp_wb_i     (rf_fp_wb),
    .rf_waddr_wb_i  (rf_waddr_wb),
    .rf_wdata_wb_i  (rf_wdata_wb),
    .fpu_valid_i    (fpu_valid),
    .fpu_ready_o    (fpu_ready),
    .fpu_fp_i       (fpu_fp),
    .fpu_waddr_i    (fpu_waddr),
    .fpu_wdata_i    (fpu_wdata),
    .rf_we_int_o    (we_int),
    .rf_waddr_int_o (waddr_int),
    .rf_wdata_int_o (wdata_int),
    .rf_we_fp_o     (we_fp),
    .rf_waddr_fp_o  (waddr_fp),
    .rf_wdata_fp_o  (wdata_fp),
    .pend_int_o     (pend_int),
    .pend_fp_o      (pend_fp),
    .idle_o         (idle)
  );

  // Apply one cycle of inputs at the falling edge, then settle before sampling.
  task automatic drive(input logic wv, input logic wf, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fv, input logic ff, input logic [4:0] fa, input logic [31:0] fd);
    @(negedge clk);
    rf_we_wb = wv; rf_fp_wb = wf; rf_waddr_wb = wa; rf_wdata_wb = wd;
    fpu_valid = fv; fpu_fp = ff; fpu_waddr = fa; fpu_wdata = fd;
    #1;
  endtask

  task automatic nop();
    drive(0, 0, 5'd0, 32'h0, 0, 0, 5'd0, 32'h0);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++; if ({fpu_ready, idle} !== 2'b11) $display("FAIL reset_ready_idle got %b exp 11", {fpu_ready, idle}); else passed++;
    checks++; if ({pend_int, pend_fp} !== 64'h0) $display("FAIL reset_pend got %h exp 0", {pend_int, pend_fp}); else passed++;
    checks++; if ({int_port, fp_port} !== 76'h0) $display("FAIL reset_ports got %h exp 0", {int_port, fp_port}); else passed++;
  endtask

  task automatic test_single();
    logic [37:0] exp0;
    exp0 = Bypass ? {1'b1, 5'd5, 32'h3F800000} : 38'h0;
    drive(0, 0, 5'd0, 32'h0, 1, 1, 5'd5, 32'h3F800000);
    checks++; if (fp_port !== exp0) $display("FAIL single_c0_fp got %h exp %h", fp_port, exp0); else passed++;
    checks++; if (pend_fp !== 32'h0) $display("FAIL single_c0_pend got %h exp 0", pend_fp); else passed++;
    nop();
    exp0 = Bypass ? 38'h0 : {1'b1, 5'd5, 32'h3F800000};
    checks++; if (fp_port !== exp0) $display("FAIL single_c1_fp got %h exp %h", fp_port, exp0); else passed++;
    checks++; if (pend_fp !== (Bypass ? 32'h0 : 32'h20)) $display("FAIL single_c1_pend got %h", pend_fp); else passed++;
    nop();
    checks++; if ({fp_port, pend_fp, idle} !== {38'h0, 32'h0, 1'b1}) $display("FAIL single_c2_quiet got %h/%h/%b exp 0/0/1", fp_port, pend_fp, idle); else passed++;
  endtask

  task automatic test_conflict();
    drive(1, 0, 5'd3, 32'h33, 1, 0, 5'd7, 32'hDEADBEEF);
    checks++; if (int_port !== {1'b1, 5'd3, 32'h33}) $display("FAIL conflict_c0_int got %h", int_port); else passed++;
    checks++; if (pend_int !== 32'h0) $display("FAIL conflict_c0_pend got %h exp 0", pend_int); else passed++;
    drive(1, 0, 5'd3, 32'h34, 0, 0, 5'd0, 32'h0);
    checks++; if (int_port !== {1'b1, 5'd3, 32'h34}) $display("FAIL conflict_c1_int got %h", int_port); else passed++;
    checks++; if (pend_int !== 32'h80) $display("FAIL conflict_c1_pend got %h exp 80", pend_int); else passed++;
    nop();
    checks++; if (int_port !== {1'b1, 5'd7, 32'hDEADBEEF}) $display("FAIL conflict_drain got %h", int_port); else passed++;
    checks++; if (pend_int !== 32'h80) $display("FAIL conflict_drain_pend got %h exp 80", pend_int); else passed++;
    nop();
    checks++; if ({int_port, pend_int, idle} !== {38'h0, 32'h0, 1'b1}) $display("FAIL conflict_after got %h/%h/%b", int_port, pend_int, idle); else passed++;
  endtask

  task automatic test_in_order();
    drive(1, 1, 5'd9, 32'hD0, 1, 1, 5'd1, 32'hA1);
    checks++; if (fp_port !== {1'b1, 5'd9, 32'hD0}) $display("FAIL order_c0_fp got %h", fp_port); else passed++;
    drive(1, 1, 5'd9, 32'hD1, 1, 0, 5'd2, 32'hB2);
    checks++; if ({int_port, fpu_ready} !== {38'h0, 1'b1}) $display("FAIL order_c1_int_ready got %h", {int_port, fpu_ready}); else passed++;
    drive(1, 1, 5'd9, 32'hD2, 0, 0, 5'd0, 32'h0);
    checks++; if (fpu_ready !== 1'b0) $display("FAIL order_full_ready got %b exp 0", fpu_ready); else passed++;
    checks++; if ({pend_fp, pend_int} !== {32'h2, 32'h4}) $display("FAIL order_pend got %h exp 0000000200000004", {pend_fp, pend_int}); else passed++;
    checks++; if (int_port !== 38'h0) $display("FAIL order_blocked_int got %h exp 0", int_port); else passed++;
    nop();
    checks++; if ({fp_port, int_port} !== {1'b1, 5'd1, 32'hA1, 38'h0}) $display("FAIL order_n got %h", {fp_port, int_port}); else passed++;
    nop();
    checks++; if ({int_port, fp_port} !== {1'b1, 5'd2, 32'hB2, 38'h0}) $display("FAIL order_n1 got %h", {int_port, fp_port}); else passed++;
    nop();
    checks++; if (idle !== 1'b1) $display("FAIL order_idle got %b exp 1", idle); else passed++;
  endtask

  task automatic test_full();
    drive(1, 1, 5'd9, 32'h0, 1, 1, 5'd10, 32'h10A);
    drive(1, 1, 5'd9, 32'h0, 1, 1, 5'd11, 32'h11B);
    drive(1, 1, 5'd9, 32'h0, 1, 1, 5'd12, 32'h12C);
    checks++; if (fpu_ready !== 1'b0) $display("FAIL full_c2_ready got %b exp 0", fpu_ready); else passed++;
    drive(1, 1, 5'd9, 32'h0, 1, 1, 5'd12, 32'h12C);
    checks++; if (fpu_ready !== 1'b0) $display("FAIL full_c3_ready got %b exp 0", fpu_ready); else passed++;
    drive(0, 0, 5'd0, 32'h0, 1, 1, 5'd12, 32'h12C);
    checks++; if ({fp_port, fpu_ready} !== {1'b1, 5'd10, 32'h10A, 1'b0}) $display("FAIL full_c4 got %h", {fp_port, fpu_ready}); else passed++;
    drive(0, 0, 5'd0, 32'h0, 1, 1, 5'd12, 32'h12C);
    checks++; if ({fp_port, fpu_ready} !== {1'b1, 5'd11, 32'h11B, 1'b1}) $display("FAIL full_c5 got %h", {fp_port, fpu_ready}); else passed++;
    nop();
    checks++; if ({fp_port, pend_fp} !== {1'b1, 5'd12, 32'h12C, 32'h1000}) $display("FAIL full_c6 got %h", {fp_port, pend_fp}); else passed++;
    nop();
    checks++; if ({fp_port, idle} !== {38'h0, 1'b1}) $display("FAIL full_no_dup got %h", {fp_port, idle}); else passed++;
  endtask

  task automatic test_back_to_back();
    logic [37:0] exp_fp;
    logic        exp_idle;
    for (int k = 0; k < 4; k++) begin
      if (k < 3) drive(0, 0, 5'd0, 32'h0, 1, 1, 5'(20 + k), 32'hC0DE0000 + 32'(20 + k));
      else       nop();
      if (Bypass) exp_fp = (k < 3) ? {1'b1, 5'(20 + k), 32'hC0DE0000 + 32'(20 + k)} : 38'h0;
      else        exp_fp = (k > 0) ? {1'b1, 5'(19 + k), 32'hC0DE0000 + 32'(19 + k)} : 38'h0;
      exp_idle = Bypass ? 1'b1 : (k == 0);
      checks++; if ({fp_port, idle} !== {exp_fp, exp_idle}) $display("FAIL b2b_c%0d got %h exp %h", k, {fp_port, idle}, {exp_fp, exp_idle}); else passed++;
    end
    nop();
    checks++; if (idle !== 1'b1) $display("FAIL b2b_idle got %b exp 1", idle); else passed++;
  endtask

  task automatic test_x0();
    drive(0, 0, 5'd0, 32'h0, 1, 0, 5'd0, 32'hFFFF);
    checks++; if ({fpu_ready, int_port} !== {1'b1, 38'h0}) $display("FAIL x0_c0 got %h", {fpu_ready, int_port}); else passed++;
    nop();
    checks++; if ({int_port, pend_int, idle} !== {38'h0, 32'h0, 1'b1}) $display("FAIL x0_c1 got %h/%h/%b", int_port, pend_int, idle); else passed++;
  endtask

  task automatic test_async_reset();
    drive(1, 1, 5'd9, 32'h0, 1, 1, 5'd3, 32'h3);
    drive(1, 1, 5'd9, 32'h0, 1, 0, 5'd4, 32'h4);
    drive(1, 1, 5'd9, 32'h0, 0, 0, 5'd0, 32'h0);
    checks++; if ({pend_fp, pend_int, fpu_ready} !== {32'h8, 32'h10, 1'b0}) $display("FAIL arst_pre got %h", {pend_fp, pend_int, fpu_ready}); else passed++;
    #1 rst_n = 1'b0;
    #1;
    checks++; if ({idle, fpu_ready, pend_fp, pend_int} !== {2'b11, 64'h0}) $display("FAIL arst_clear got %h", {idle, fpu_ready, pend_fp, pend_int}); else passed++;
    rf_we_wb = 1'b0; rf_fp_wb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      nop();
      checks++; if ({int_port, fp_port, idle} !== {76'h0, 1'b1}) $display("FAIL arst_post_c%0d got %h", k, {int_port, fp_port, idle}); else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_conflict();
    test_in_order();
    test_full();
    test_back_to_back();
    test_x0();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
